// File: rtl/pll_cfg_responder.sv
// Avalon-MM stand-in for the PLL reconfiguration port: shadow divider registers,
// a modelled busy window (optionally stalling via waitrequest), commit, then relock.
module pll_cfg_responder #(
  parameter int BUSY_CYCLES = 16,
  parameter int LOCK_CYCLES = 8
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [5:0]  mgmt_address,
  input  logic        mgmt_write,
  input  logic [31:0] mgmt_writedata,
  input  logic        mgmt_read,
  output logic [31:0] mgmt_readdata,
  output logic        mgmt_waitrequest,
  output logic [8:0]  n_div,
  output logic [8:0]  m_div,
  output logic [8:0]  c0_div,
  output logic [31:0] m_frac,
  output logic        cfg_applied,
  output logic        locked
);

  localparam int CNT_MAX = (BUSY_CYCLES > LOCK_CYCLES) ? BUSY_CYCLES : LOCK_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [5:0] A_MODE   = 6'd0;
  localparam logic [5:0] A_STATUS = 6'd1;
  localparam logic [5:0] A_START  = 6'd2;
  localparam logic [5:0] A_N      = 6'd3;
  localparam logic [5:0] A_M      = 6'd4;
  localparam logic [5:0] A_C0     = 6'd5;
  localparam logic [5:0] A_MFRAC  = 6'd7;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RELOCK} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_mode;
  logic [31:0]   r_n_sh, r_m_sh, r_c0_sh, r_mfrac_sh;
  logic [8:0]    r_n_div, r_m_div, r_c0_div;
  logic [31:0]   r_m_frac;
  logic          r_wait, r_applied, r_locked;

  logic          w_wr_ok;
  logic          w_start;
  logic [31:0]   w_rdata;

  // Counter word [16:0] -> divide; a zero half-count means 256, sum wraps at 9 bits.
  function automatic logic [8:0] f_div(input logic [16:0] w);
    logic [8:0] hi, lo;
    hi = (w[15:8] == 8'd0) ? 9'd256 : {1'b0, w[15:8]};
    lo = (w[7:0]  == 8'd0) ? 9'd256 : {1'b0, w[7:0]};
    return w[16] ? 9'd1 : 9'(hi + lo);
  endfunction

  assign w_wr_ok = mgmt_write && !r_wait;
  assign w_start = w_wr_ok && (mgmt_address == A_START) && (r_state != S_BUSY);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state    <= S_RELOCK;
      r_cnt      <= CW'(LOCK_CYCLES);
      r_mode     <= 1'b0;
      r_n_sh     <= '0;
      r_m_sh     <= '0;
      r_c0_sh    <= '0;
      r_mfrac_sh <= '0;
      r_n_div    <= 9'd1;
      r_m_div    <= 9'd1;
      r_c0_div   <= 9'd1;
      r_m_frac   <= '0;
      r_wait     <= 1'b0;
      r_applied  <= 1'b0;
      r_locked   <= 1'b0;
    end else begin
      r_applied <= 1'b0;

      // Shadow writes go through in any state once the transfer is not stalled.
      if (w_wr_ok) begin
        case (mgmt_address)
          A_MODE:  r_mode     <= mgmt_writedata[0];
          A_N:     r_n_sh     <= mgmt_writedata;
          A_M:     r_m_sh     <= mgmt_writedata;
          A_C0:    r_c0_sh    <= mgmt_writedata;
          A_MFRAC: r_mfrac_sh <= mgmt_writedata;
          default: ;
        endcase
      end

      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state  <= S_BUSY;
            r_cnt    <= CW'(BUSY_CYCLES);
            r_wait   <= !r_mode;
            r_locked <= 1'b0;
          end
        end
        S_BUSY: begin
          if (r_cnt == CW'(1)) begin
            r_state   <= S_RELOCK;
            r_cnt     <= CW'(LOCK_CYCLES);
            r_wait    <= 1'b0;
            r_applied <= 1'b1;
            r_locked  <= 1'b0;
            r_n_div   <= f_div(r_n_sh[16:0]);
            r_m_div   <= f_div(r_m_sh[16:0]);
            r_c0_div  <= f_div(r_c0_sh[16:0]);
            r_m_frac  <= r_mfrac_sh;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_RELOCK: begin
          if (w_start) begin
            r_state <= S_BUSY;
            r_cnt   <= CW'(BUSY_CYCLES);
            r_wait  <= !r_mode;
          end else if (r_cnt == CW'(1)) begin
            r_state  <= S_IDLE;
            r_locked <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: begin
          r_state <= S_RELOCK;
          r_cnt   <= CW'(LOCK_CYCLES);
        end
      endcase
    end
  end

  // Read path sees register values before any same-cycle write lands.
  always_comb begin
    w_rdata = '0;
    if (mgmt_read) begin
      case (mgmt_address)
        A_MODE:   w_rdata = {31'd0, r_mode};
        A_STATUS: w_rdata = {31'd0, (r_state != S_BUSY)};
        A_N:      w_rdata = r_n_sh;
        A_M:      w_rdata = r_m_sh;
        A_C0:     w_rdata = r_c0_sh;
        A_MFRAC:  w_rdata = r_mfrac_sh;
        default:  w_rdata = '0;
      endcase
    end
  end

  assign mgmt_readdata    = w_rdata;
  assign mgmt_waitrequest = r_wait;
  assign n_div            = r_n_div;
  assign m_div            = r_m_div;
  assign c0_div           = r_c0_div;
  assign m_frac           = r_m_frac;
  assign cfg_applied      = r_applied;
  assign locked           = r_locked;

endmodule

// File: tb/tb_pll_cfg_responder.sv
// Scoreboard bench for pll_cfg_responder: expected reads and commits are queued by the
// stimulus thread and checked by a negedge monitor when the DUT presents them.
module tb_pll_cfg_responder;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic [5:0]  mgmt_address = '0;
  logic        mgmt_write = 1'b0;
  logic [31:0] mgmt_writedata = '0;
  logic        mgmt_read = 1'b0;
  logic [31:0] mgmt_readdata;
  logic        mgmt_waitrequest;
  logic [8:0]  n_div, m_div, c0_div;
  logic [31:0] m_frac;
  logic        cfg_applied, locked;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [31:0] rd_q[$];
  logic [63:0] cm_q[$];

  pll_cfg_responder #(.BUSY_CYCLES(16), .LOCK_CYCLES(8)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .mgmt_address(mgmt_address), .mgmt_write(mgmt_write),
    .mgmt_writedata(mgmt_writedata), .mgmt_read(mgmt_read),
    .mgmt_readdata(mgmt_readdata), .mgmt_waitrequest(mgmt_waitrequest),
    .n_div(n_div), .m_div(m_div), .c0_div(c0_div), .m_frac(m_frac),
    .cfg_applied(cfg_applied), .locked(locked)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever a read completes or a commit pulses.
  always @(negedge clk_sys) begin
    if (!reset) begin
      if (mgmt_read && !mgmt_waitrequest) begin
        if (rd_q.size() == 0) chk("rd_unexpected", 64'(mgmt_readdata), 64'hDEAD);
        else chk("rd_data", 64'(mgmt_readdata), 64'(rd_q.pop_front()));
      end
      if (cfg_applied) begin
        if (cm_q.size() == 0) chk("commit_unexpected", 64'(n_div), 64'hDEAD);
        else chk("commit_divs", {5'd0, n_div, m_div, c0_div, m_frac}, cm_q.pop_front());
      end
    end
  end

  task automatic xfer(input logic [5:0] a, input logic wr, input logic rd, input logic [31:0] d);
    int n = 0;
    mgmt_address = a; mgmt_writedata = d; mgmt_write = wr; mgmt_read = rd;
    forever begin
      @(negedge clk_sys);
      if (!mgmt_waitrequest) break;
      n++;
      if (n > 200) begin
        chk("xfer_timeout", 64'(n), 64'd0);
        break;
      end
    end
    @(posedge clk_sys); #1;
    mgmt_write = 1'b0; mgmt_read = 1'b0;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    xfer(a, 1'b1, 1'b0, d);
  endtask

  task automatic rd(input logic [5:0] a, input logic [31:0] exp);
    rd_q.push_back(exp);
    xfer(a, 1'b0, 1'b1, 32'd0);
  endtask

  task automatic wait_lock(output int n);
    n = 0;
    while (!locked && n < 100) begin
      @(posedge clk_sys); #1; n++;
    end
  endtask

  task automatic count_wait(output int n);
    n = 0;
    while (mgmt_waitrequest && n < 100) begin
      @(posedge clk_sys); #1; n++;
    end
  endtask

  function automatic logic [63:0] cm(input logic [8:0] n, m, c, input logic [31:0] f);
    return {5'd0, n, m, c, f};
  endfunction

  initial begin
    int n;
    int st;
    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_locked", 64'(locked), 64'd0);
    chk("rst_wait", 64'(mgmt_waitrequest), 64'd0);
    chk("rst_divs", {n_div, m_div, c0_div}, {9'd1, 9'd1, 9'd1});
    chk("rst_mfrac", 64'(m_frac), 64'd0);
    chk("rst_applied", 64'(cfg_applied), 64'd0);
    chk("rst_rdata", 64'(mgmt_readdata), 64'd0);
    reset = 1'b0;
    wait_lock(n);
    chk("lock_after_reset", 64'(n), 64'd8);

    // Waitrequest-mode reconfiguration
    wr(6'd0, 32'd0);
    wr(6'd3, 32'h0001_0000);
    wr(6'd4, 32'h0000_0404);
    wr(6'd5, 32'h0000_0505);
    wr(6'd7, 32'h9745_BF27);
    cm_q.push_back(cm(9'd1, 9'd8, 9'd10, 32'h9745_BF27));
    wr(6'd2, 32'd0);
    chk("locked_drop_on_start", 64'(locked), 64'd0);
    count_wait(n);
    chk("wait_cycles_1", 64'(n), 64'd16);
    wait_lock(n);
    chk("relock_cycles_1", 64'(n), 64'd8);
    rd(6'd5, 32'h0000_0505);
    rd(6'd1, 32'd1);

    // Second configuration
    wr(6'd5, 32'h0002_0504);
    wr(6'd7, 32'hA3D7_09E8);
    cm_q.push_back(cm(9'd1, 9'd8, 9'd9, 32'hA3D7_09E8));
    wr(6'd2, 32'd0);
    count_wait(n);
    chk("wait_cycles_2", 64'(n), 64'd16);
    wait_lock(n);
    chk("relock_cycles_2", 64'(n), 64'd8);

    // Same-cycle read and write: read returns the old word
    rd_q.push_back(32'h0000_0404);
    xfer(6'd4, 1'b1, 1'b1, 32'h0000_0404);
    rd(6'd4, 32'h0000_0404);

    // Polling mode: shadow write in BUSY lands, second START ignored
    wr(6'd0, 32'd1);
    rd(6'd0, 32'd1);
    wr(6'd2, 32'd0);
    st = cyc;
    chk("poll_no_wait", 64'(mgmt_waitrequest), 64'd0);
    rd(6'd1, 32'd0);
    wr(6'd3, 32'h0000_0302);
    wr(6'd2, 32'd0);
    cm_q.push_back(cm(9'd5, 9'd8, 9'd9, 32'hA3D7_09E8));
    n = 0;
    while (!cfg_applied && n < 100) begin
      @(posedge clk_sys); #1; n++;
    end
    chk("poll_commit_latency", 64'(cyc - st), 64'd16);
    rd(6'd1, 32'd1);
    wait_lock(n);
    chk("poll_locked", 64'(locked), 64'd1);

    // Reset in the middle of BUSY aborts without commit
    wr(6'd0, 32'd0);
    wr(6'd2, 32'd0);
    repeat (4) @(posedge clk_sys);
    #1;
    chk("busy_wait_before_rst", 64'(mgmt_waitrequest), 64'd1);
    reset = 1'b1;
    #1;
    chk("abort_wait", 64'(mgmt_waitrequest), 64'd0);
    chk("abort_divs", {n_div, m_div, c0_div}, {9'd1, 9'd1, 9'd1});
    chk("abort_mfrac", 64'(m_frac), 64'd0);
    chk("abort_locked", 64'(locked), 64'd0);
    @(posedge clk_sys); #1;
    reset = 1'b0;
    wait_lock(n);
    chk("lock_after_abort", 64'(n), 64'd8);
    repeat (20) @(posedge clk_sys);
    #1;
    chk("abort_no_commit_divs", {n_div, m_div, c0_div}, {9'd1, 9'd1, 9'd1});
    rd(6'd0, 32'd0);

    // Unmapped address and 512 -> 0 wrap
    wr(6'd6, 32'hFFFF_FFFF);
    rd(6'd6, 32'd0);
    wr(6'd3, 32'h0001_0000);
    wr(6'd4, 32'h0000_0404);
    wr(6'd5, 32'h0000_0000);
    wr(6'd7, 32'h0000_0001);
    cm_q.push_back(cm(9'd1, 9'd8, 9'd0, 32'h0000_0001));
    wr(6'd2, 32'd0);
    count_wait(n);
    chk("wait_cycles_3", 64'(n), 64'd16);
    wait_lock(n);
    chk("relock_cycles_3", 64'(n), 64'd8);
    chk("c0_wrap_zero", 64'(c0_div), 64'd0);
    rd(6'd5, 32'd0);

    repeat (2) @(posedge clk_sys);
    chk("rd_q_drained", 64'(rd_q.size()), 64'd0);
    chk("cm_q_drained", 64'(cm_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
